vga_axil_cfg_ctrl: RTL and testbench

//   AXI-Lite slave controller that configures the VGA timing/pixel path. Runs

---
 rtl/vga_axil_cfg_ctrl.sv | 269 ++++++++++++++++++++++++++
 tb/tb_vga_axil_cfg_ctrl.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_axil_cfg_ctrl.sv
// AXI-Lite configuration slave for the VGA pipeline: staging register bank behind
// independent write/read channel FSMs, committed to cfg_* only at frame boundaries.
module vga_axil_cfg_ctrl #(
    parameter int AXIL_ADDR_W = 8,
    parameter int AXIL_DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       arst_n,
    // write address / data / response channels
    input  logic [AXIL_ADDR_W-1:0]     awaddr,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [AXIL_DATA_W-1:0]     wdata,
    input  logic [AXIL_DATA_W/8-1:0]   wstrb,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    // read address / data channels
    input  logic [AXIL_ADDR_W-1:0]     araddr,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [AXIL_DATA_W-1:0]     rdata,
    output logic [1:0]                 rresp,
    output logic                       rvalid,
    input  logic                       rready,
    // timing generator side
    input  logic                       frame_start_i,
    output logic                       cfg_enable_o,
    output logic [11:0]                cfg_h_active_o,
    output logic [11:0]                cfg_v_active_o,
    output logic [11:0]                cfg_color_o
);

    localparam int IDX_W = AXIL_ADDR_W - 2;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    localparam logic [11:0] H_ACTIVE_RST = 12'd640;
    localparam logic [11:0] V_ACTIVE_RST = 12'd480;

    typedef enum logic [2:0] {
        SEL_CTRL,
        SEL_H_ACTIVE,
        SEL_V_ACTIVE,
        SEL_COLOR,
        SEL_STATUS,
        SEL_NONE
    } reg_sel_e;

    typedef enum logic { W_IDLE, W_RESP } w_state_e;
    typedef enum logic { R_IDLE, R_DATA } r_state_e;

    // Word-aligned decode; the two byte-offset bits never take part.
    function automatic reg_sel_e decode(input logic [AXIL_ADDR_W-1:0] addr);
        logic [IDX_W-1:0] idx;
        idx = addr[AXIL_ADDR_W-1:2];
        case (idx)
            IDX_W'(0): return SEL_CTRL;
            IDX_W'(1): return SEL_H_ACTIVE;
            IDX_W'(2): return SEL_V_ACTIVE;
            IDX_W'(3): return SEL_COLOR;
            IDX_W'(4): return SEL_STATUS;
            default:   return SEL_NONE;
        endcase
    endfunction

    // Every field fits in byte lanes 0 and 1, so only those strobes matter.
    function automatic logic [11:0] merge_field(
        input logic [11:0] cur,
        input logic [11:0] data,
        input logic [1:0]  strb
    );
        logic [11:0] res;
        res[7:0]  = strb[0] ? data[7:0]  : cur[7:0];
        res[11:8] = strb[1] ? data[11:8] : cur[11:8];
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Staging bank and commit state
    // ------------------------------------------------------------------
    logic        stg_enable;
    logic [11:0] stg_h_active;
    logic [11:0] stg_v_active;
    logic [11:0] stg_color;
    logic        pending;
    logic        commit_now;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_e    w_state;
    logic        aw_held;
    logic        w_held;
    reg_sel_e    aw_sel_q;
    logic [11:0] w_data_q;
    logic [1:0]  w_strb_q;

    logic        aw_fire;
    logic        w_fire;
    logic        wr_go;
    logic        wr_ok;
    reg_sel_e    wr_sel;
    logic [11:0] wr_data;
    logic [1:0]  wr_strb;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        aw_fire = awvalid && awready;
        w_fire  = wvalid && wready;
        wr_sel  = aw_held ? aw_sel_q : decode(awaddr);
        wr_data = w_held  ? w_data_q : wdata[11:0];
        wr_strb = w_held  ? w_strb_q : wstrb[1:0];
        wr_go   = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
        wr_ok   = wr_go && (wr_sel != SEL_STATUS) && (wr_sel != SEL_NONE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every block sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            w_state  <= W_IDLE;
            awready  <= 1'b1;
            wready   <= 1'b1;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_sel_q <= SEL_NONE;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wr_go) begin
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        awready <= 1'b0;
                        wready  <= 1'b0;
                        bvalid  <= 1'b1;
                        bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                        w_state <= W_RESP;
                    end else begin
                        // Only one half has arrived: park it and close that channel.
                        if (aw_fire) begin
                            aw_held  <= 1'b1;
                            awready  <= 1'b0;
                            aw_sel_q <= decode(awaddr);
                        end
                        if (w_fire) begin
                            w_held   <= 1'b1;
                            wready   <= 1'b0;
                            w_data_q <= wdata[11:0];
                            w_strb_q <= wstrb[1:0];
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Staging writes and frame-synchronous commit
    // ------------------------------------------------------------------
    assign commit_now = pending && (frame_start_i || !cfg_enable_o);

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            stg_enable     <= 1'b0;
            stg_h_active   <= H_ACTIVE_RST;
            stg_v_active   <= V_ACTIVE_RST;
            stg_color      <= '0;
            cfg_enable_o   <= 1'b0;
            cfg_h_active_o <= H_ACTIVE_RST;
            cfg_v_active_o <= V_ACTIVE_RST;
            cfg_color_o    <= '0;
            pending        <= 1'b0;
        end else begin
            if (commit_now) begin
                cfg_enable_o   <= stg_enable;
                cfg_h_active_o <= stg_h_active;
                cfg_v_active_o <= stg_v_active;
                cfg_color_o    <= stg_color;
                pending        <= 1'b0;
            end
            // A write landing on a commit cycle wins: the commit above took the
            // old staging values and the new ones stay pending for next frame.
            if (wr_ok) begin
                pending <= 1'b1;
                case (wr_sel)
                    SEL_CTRL:     stg_enable   <= wr_strb[0] ? wr_data[0] : stg_enable;
                    SEL_H_ACTIVE: stg_h_active <= merge_field(stg_h_active, wr_data, wr_strb);
                    SEL_V_ACTIVE: stg_v_active <= merge_field(stg_v_active, wr_data, wr_strb);
                    SEL_COLOR:    stg_color    <= merge_field(stg_color, wr_data, wr_strb);
                    default:      ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_e               r_state;
    reg_sel_e               rd_sel;
    logic [AXIL_DATA_W-1:0] rd_word;
    logic [1:0]             rd_resp;

    always_comb begin
        rd_sel  = decode(araddr);
        rd_word = '0;
        rd_resp = RESP_OKAY;
        case (rd_sel)
            SEL_CTRL:     rd_word[0]    = stg_enable;
            SEL_H_ACTIVE: rd_word[11:0] = stg_h_active;
            SEL_V_ACTIVE: rd_word[11:0] = stg_v_active;
            SEL_COLOR:    rd_word[11:0] = stg_color;
            SEL_STATUS:   rd_word[0]    = pending;
            default:      rd_resp       = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state <= R_IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rresp   <= RESP_OKAY;
            rdata   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid) begin
                        rdata   <= rd_word;
                        rresp   <= rd_resp;
                        rvalid  <= 1'b1;
                        arready <= 1'b0;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Byte-offset address bits and data/strobe lanes above bit 11 carry no state.
    logic unused_bits;
    assign unused_bits = ^{awaddr[1:0], araddr[1:0],
                           wdata[AXIL_DATA_W-1:12], wstrb[AXIL_DATA_W/8-1:2]};

endmodule

// File: tb/tb_vga_axil_cfg_ctrl.sv
// Self-checking bench for vga_axil_cfg_ctrl: directed scenarios plus randomized
// traffic compared against a register-level model of staging/committed state.
module tb_vga_axil_cfg_ctrl;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        frame_start_i;
    logic        cfg_enable_o;
    logic [11:0] cfg_h_active_o;
    logic [11:0] cfg_v_active_o;
    logic [11:0] cfg_color_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: index 0 CTRL, 1 H_ACTIVE, 2 V_ACTIVE, 3 COLOR
    logic [11:0] m_stg [4];
    logic [11:0] m_cmt [4];
    bit          m_pend;

    always #5 clk = ~clk;

    vga_axil_cfg_ctrl #(.AXIL_ADDR_W(8), .AXIL_DATA_W(32)) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .awaddr         (awaddr),
        .awvalid        (awvalid),
        .awready        (awready),
        .wdata          (wdata),
        .wstrb          (wstrb),
        .wvalid         (wvalid),
        .wready         (wready),
        .bresp          (bresp),
        .bvalid         (bvalid),
        .bready         (bready),
        .araddr         (araddr),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rvalid         (rvalid),
        .rready         (rready),
        .frame_start_i  (frame_start_i),
        .cfg_enable_o   (cfg_enable_o),
        .cfg_h_active_o (cfg_h_active_o),
        .cfg_v_active_o (cfg_v_active_o),
        .cfg_color_o    (cfg_color_o)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic m_reset();
        m_stg[0] = 12'd0;   m_stg[1] = 12'd640; m_stg[2] = 12'd480; m_stg[3] = 12'd0;
        for (int i = 0; i < 4; i++) m_cmt[i] = m_stg[i];
        m_pend = 1'b0;
    endtask

    task automatic m_commit();
        for (int i = 0; i < 4; i++) m_cmt[i] = m_stg[i];
        m_pend = 1'b0;
    endtask

    function automatic int m_index(input logic [7:0] addr);
        int w;
        w = int'(addr) / 4;
        return (w <= 4) ? w : -1;
    endfunction

    function automatic logic [31:0] m_read_data(input logic [7:0] addr);
        int idx;
        idx = m_index(addr);
        if (idx >= 0 && idx < 4) return {20'd0, m_stg[idx]};
        if (idx == 4) return {31'd0, m_pend};
        return 32'd0;
    endfunction

    function automatic logic [1:0] m_read_resp(input logic [7:0] addr);
        return (m_index(addr) >= 0) ? 2'b00 : 2'b10;
    endfunction

    task automatic m_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
        int idx;
        logic [31:0] word;
        idx = m_index(addr);
        if (idx >= 0 && idx < 4) begin
            word = {20'd0, m_stg[idx]};
            for (int b = 0; b < 4; b++)
                if (strb[b]) word[b*8 +: 8] = data[b*8 +: 8];
            m_stg[idx] = (idx == 0) ? {11'd0, word[0]} : word[11:0];
            m_pend = 1'b1;
            resp = 2'b00;
        end else begin
            resp = 2'b10;
        end
    endtask

    // Idle two cycles; a disabled display commits on its own during this time.
    task automatic settle();
        bit auto_commit;
        auto_commit = m_pend && (m_cmt[0][0] == 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        if (auto_commit) m_commit();
    endtask

    task automatic pulse_frame();
        frame_start_i = 1'b1;
        @(posedge clk); #1;
        frame_start_i = 1'b0;
        if (m_pend) m_commit();
    endtask

    // ---------------- bus drivers ----------------
    task automatic axi_aw_w(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly);
        bit aw_done, w_done, aw_go, w_go;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            aw_go   = awvalid && awready;
            w_go    = wvalid && wready;
            if (aw_done && !w_done) begin
                n_checks++;
                if (awready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL awready_held: got %b expected 0", awready);
                end
            end
            @(posedge clk); #1;
            if (aw_go) aw_done = 1;
            if (w_go)  w_done  = 1;
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        n_checks++;
        if (!(aw_done && w_done)) begin
            n_fail++;
            $display("FAIL aw_w_accept: aw=%0d w=%0d after %0d cycles", aw_done, w_done, cyc);
        end
    endtask

    task automatic axi_b(input int b_dly, output logic [1:0] resp);
        int cyc;
        cyc = 0;
        while (bvalid !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        n_checks++;
        if (bvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL bvalid_timeout: got %b expected 1", bvalid);
        end
        resp = bresp;
        for (int i = 0; i < b_dly; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({bvalid, bresp, awready, wready} !== {1'b1, resp, 2'b00}) begin
                n_fail++;
                $display("FAIL b_hold: got v=%b r=%b awr=%b wr=%b expected v=1 r=%b awr=0 wr=0",
                         bvalid, bresp, awready, wready, resp);
            end
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        n_checks++;
        if ({bvalid, awready, wready} !== 3'b011) begin
            n_fail++;
            $display("FAIL b_release: got v=%b awr=%b wr=%b expected 0 1 1", bvalid, awready, wready);
        end
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp);
        axi_aw_w(addr, data, strb, aw_dly, w_dly);
        axi_b(b_dly, resp);
    endtask

    task automatic axi_read(input logic [7:0] addr, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        cyc = 0;
        araddr  = addr;
        arvalid = 1'b1;
        while (arready !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n_checks++;
        if ({rvalid, arready} !== 2'b10) begin
            n_fail++;
            $display("FAIL rd_latency: got rvalid=%b arready=%b expected 1 0", rvalid, arready);
        end
        data = rdata;
        resp = rresp;
        for (int i = 0; i < r_dly; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({rvalid, rdata, rresp} !== {1'b1, data, resp}) begin
                n_fail++;
                $display("FAIL r_hold: got v=%b d=%h r=%b expected v=1 d=%h r=%b",
                         rvalid, rdata, rresp, data, resp);
            end
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        n_checks++;
        if ({rvalid, arready} !== 2'b01) begin
            n_fail++;
            $display("FAIL r_release: got rvalid=%b arready=%b expected 0 1", rvalid, arready);
        end
    endtask

    // Read a register and compare it against the model.
    task automatic read_expect(input string name, input logic [7:0] addr, input int r_dly);
        logic [31:0] d, exp_d;
        logic [1:0]  r, exp_r;
        exp_d = m_read_data(addr);
        exp_r = m_read_resp(addr);
        axi_read(addr, r_dly, d, r);
        n_checks++;
        if ({d, r} !== {exp_d, exp_r}) begin
            n_fail++;
            $display("FAIL %s: got data=%h resp=%b expected data=%h resp=%b", name, d, r, exp_d, exp_r);
        end
    endtask

    task automatic write_expect(input string name, input logic [7:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input int aw_dly, input int w_dly, input int b_dly);
        logic [1:0] r, exp_r;
        axi_write(addr, data, strb, aw_dly, w_dly, b_dly, r);
        m_write(addr, data, strb, exp_r);
        n_checks++;
        if (r !== exp_r) begin
            n_fail++;
            $display("FAIL %s: got bresp=%b expected %b", name, r, exp_r);
        end
        settle();
    endtask

    task automatic do_reset();
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; frame_start_i = 0;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
        arst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        arst_n = 1'b1;
        m_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({cfg_enable_o, cfg_h_active_o, cfg_v_active_o, cfg_color_o} !==
            {1'b0, 12'd640, 12'd480, 12'd0}) begin
            n_fail++;
            $display("FAIL reset_cfg: got en=%b h=%0d v=%0d c=%h expected 0 640 480 000",
                     cfg_enable_o, cfg_h_active_o, cfg_v_active_o, cfg_color_o);
        end
        n_checks++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !==
            {3'b111, 2'b00, 4'b0000, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_bus: got awr=%b wr=%b arr=%b bv=%b rv=%b br=%b rr=%b rd=%h expected 1 1 1 0 0 00 00 0",
                     awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
        end
        read_expect("reset_read_h", 8'h04, 0);
        read_expect("reset_read_status", 8'h10, 0);
    endtask

    task automatic test_enable_commit();
        write_expect("enable_wr", 8'h00, 32'h1, 4'hF, 0, 0, 0);
        n_checks++;
        if (cfg_enable_o !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_commit: got %b expected 1", cfg_enable_o);
        end
        write_expect("h800_wr", 8'h04, 32'd800, 4'hF, 0, 0, 0);
        read_expect("h800_status_pending", 8'h10, 0);
        repeat (5) begin @(posedge clk); #1; end
        n_checks++;
        if (cfg_h_active_o !== 12'd640) begin
            n_fail++;
            $display("FAIL h_held_mid_frame: got %0d expected 640", cfg_h_active_o);
        end
        pulse_frame();
        n_checks++;
        if (cfg_h_active_o !== 12'd800) begin
            n_fail++;
            $display("FAIL h_frame_commit: got %0d expected 800", cfg_h_active_o);
        end
        read_expect("h800_status_clear", 8'h10, 0);
    endtask

    task automatic test_split_aw_w();
        write_expect("split_wr", 8'h08, 32'd123, 4'hF, 0, 3, 4);
        read_expect("split_readback", 8'h08, 2);
        read_expect("split_status", 8'h10, 0);
        pulse_frame();
        n_checks++;
        if ({cfg_enable_o, cfg_h_active_o, cfg_v_active_o, cfg_color_o} !==
            {m_cmt[0][0], m_cmt[1], m_cmt[2], m_cmt[3]}) begin
            n_fail++;
            $display("FAIL split_commit: got v=%0d expected v=%0d", cfg_v_active_o, m_cmt[2]);
        end
    endtask

    task automatic test_wstrb();
        write_expect("wstrb_wr", 8'h0C, 32'hFFF, 4'b0001, 1, 0, 1);
        read_expect("wstrb_readback", 8'h0C, 0);
        n_checks++;
        if (m_stg[3] !== 12'h0FF) begin
            n_fail++;
            $display("FAIL wstrb_model: got %h expected 0ff", m_stg[3]);
        end
        pulse_frame();
        n_checks++;
        if (cfg_color_o !== m_cmt[3]) begin
            n_fail++;
            $display("FAIL wstrb_commit: got %h expected %h", cfg_color_o, m_cmt[3]);
        end
    endtask

    task automatic test_slverr();
        write_expect("slverr_wr_20", 8'h20, 32'hABC, 4'hF, 0, 0, 0);
        write_expect("slverr_wr_status", 8'h10, 32'h1, 4'hF, 0, 0, 0);
        read_expect("slverr_status", 8'h10, 0);
        read_expect("slverr_rd_20", 8'h20, 1);
        read_expect("slverr_h_unchanged", 8'h04, 0);
        read_expect("slverr_color_unchanged", 8'h0C, 0);
    endtask

    task automatic test_commit_collision();
        logic [31:0] exp_rd;
        logic [1:0]  exp_b, r;
        write_expect("coll_first_wr", 8'h08, 32'd100, 4'hF, 0, 0, 0);
        exp_rd = m_read_data(8'h08);
        awaddr = 8'h08; wdata = 32'd200; wstrb = 4'hF;
        araddr = 8'h08;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; frame_start_i = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; frame_start_i = 1'b0;
        m_commit();
        m_write(8'h08, 32'd200, 4'hF, exp_b);
        n_checks++;
        if ({rvalid, rdata, rresp} !== {1'b1, exp_rd, 2'b00}) begin
            n_fail++;
            $display("FAIL same_cycle_read: got v=%b d=%h r=%b expected v=1 d=%h r=00",
                     rvalid, rdata, rresp, exp_rd);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        axi_b(0, r);
        n_checks++;
        if (r !== exp_b) begin
            n_fail++;
            $display("FAIL coll_bresp: got %b expected %b", r, exp_b);
        end
        n_checks++;
        if (cfg_v_active_o !== m_cmt[2]) begin
            n_fail++;
            $display("FAIL coll_old_committed: got %0d expected %0d", cfg_v_active_o, m_cmt[2]);
        end
        read_expect("coll_still_pending", 8'h10, 0);
        pulse_frame();
        n_checks++;
        if (cfg_v_active_o !== m_cmt[2]) begin
            n_fail++;
            $display("FAIL coll_next_frame: got %0d expected %0d", cfg_v_active_o, m_cmt[2]);
        end
    endtask

    task automatic test_random();
        logic [7:0] bases [8];
        logic [7:0] addr;
        int op;
        bases = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'hFC};
        for (int it = 0; it < 80; it++) begin
            op   = int'($urandom_range(0, 9));
            addr = bases[$urandom_range(0, 7)] | 8'($urandom_range(0, 3));
            if (op <= 4) begin
                write_expect("rand_wr", addr, $urandom, 4'($urandom_range(0, 15)),
                             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                             int'($urandom_range(0, 3)));
            end else if (op <= 7) begin
                read_expect("rand_rd", addr, int'($urandom_range(0, 2)));
            end else if (op == 8) begin
                pulse_frame();
            end else begin
                settle();
            end
            n_checks++;
            if ({cfg_enable_o, cfg_h_active_o, cfg_v_active_o, cfg_color_o} !==
                {m_cmt[0][0], m_cmt[1], m_cmt[2], m_cmt[3]}) begin
                n_fail++;
                $display("FAIL rand_cfg it=%0d: got en=%b h=%h v=%h c=%h expected en=%b h=%h v=%h c=%h",
                         it, cfg_enable_o, cfg_h_active_o, cfg_v_active_o, cfg_color_o,
                         m_cmt[0][0], m_cmt[1], m_cmt[2], m_cmt[3]);
            end
        end
    endtask

    task automatic test_reset_in_resp();
        axi_aw_w(8'h04, 32'd999, 4'hF, 0, 0);
        n_checks++;
        if (bvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL resp_before_reset: got bvalid=%b expected 1", bvalid);
        end
        arst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({bvalid, awready, wready} !== 3'b011) begin
            n_fail++;
            $display("FAIL reset_in_resp: got bv=%b awr=%b wr=%b expected 0 1 1", bvalid, awready, wready);
        end
        arst_n = 1'b1;
        m_reset();
        repeat (2) begin @(posedge clk); #1; end
        n_checks++;
        if (bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_resp_after_reset: got bvalid=%b expected 0", bvalid);
        end
        read_expect("reset_in_resp_h", 8'h04, 0);
    endtask

    initial begin
        test_reset();
        test_enable_commit();
        test_split_aw_w();
        test_wstrb();
        test_slverr();
        test_commit_collision();
        test_random();
        test_reset_in_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
